mux_nway_rr: RTL and testbench

MUX_NWAY_RR -- requirements
Module: mux_nway_rr

---
 rtl/mux_nway_rr.sv | 119 +++++++++++
 tb/tb_mux_nway_rr.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_nway_rr.sv
//==============================================================================
// Module   : mux_nway_rr
// Brief    : N-channel valid/ready mux with fixed-select or round-robin
//            arbitration feeding a one-entry registered output stage.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mux_nway_rr #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] c_last_chan = SELW'(N - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [SELW-1:0]  r_ptr;

    logic [WIDTH-1:0] w_chan [N];
    logic [2*N-1:0]   w_rot;
    logic             w_rr_vld;
    logic [SELW-1:0]  w_rr_idx;
    int               w_sum;
    logic             w_cand_vld;
    logic [SELW-1:0]  w_cand_idx;
    logic             w_can_accept;
    logic             w_grant_en;
    logic             w_xfer;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_unpack
            assign w_chan[k] = in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate valids so bit 0 is the channel at ptr; first set bit wins.
    always_comb begin
        w_rot    = {in_valid, in_valid} >> r_ptr;
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        w_sum    = 0;
        for (int i = 0; i < N; i++) begin
            if (!w_rr_vld && w_rot[i]) begin
                w_rr_vld = 1'b1;
                w_sum    = int'(r_ptr) + i;
                if (w_sum >= N) begin
                    w_sum = w_sum - N;
                end
                w_rr_idx = SELW'(w_sum);
            end
        end
    end

    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_idx = '0;
        if (mode) begin
            w_cand_vld = w_rr_vld;
            w_cand_idx = w_rr_idx;
        end else if (int'(sel) < N) begin
            w_cand_vld = 1'b1;
            w_cand_idx = sel;
        end
    end

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_grant_en   = w_cand_vld && w_can_accept && !reset;

    generate
        for (k = 0; k < N; k++) begin : g_ready
            assign in_ready[k] = w_grant_en && (w_cand_idx == SELW'(k));
        end
    endgenerate

    assign w_xfer = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_chan[w_cand_idx];
                r_out_chan  <= w_cand_idx;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && mode) begin
                r_ptr <= (w_cand_idx == c_last_chan) ? '0 : w_cand_idx + 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_nway_rr.sv
//==============================================================================
// Module   : tb_mux_nway_rr
// Brief    : Directed self-checking bench for mux_nway_rr (N=8 and N=5 builds).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mux_nway_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=8 instance
    logic          a_reset;
    logic [127:0]  a_in_data;
    logic [7:0]    a_in_valid;
    logic [7:0]    a_in_ready;
    logic          a_mode;
    logic [2:0]    a_sel;
    logic [15:0]   a_out_data;
    logic [2:0]    a_out_chan;
    logic          a_out_valid;
    logic          a_out_ready;

    // N=5 instance
    logic          b_reset;
    logic [79:0]   b_in_data;
    logic [4:0]    b_in_valid;
    logic [4:0]    b_in_ready;
    logic          b_mode;
    logic [2:0]    b_sel;
    logic [15:0]   b_out_data;
    logic [2:0]    b_out_chan;
    logic          b_out_valid;
    logic          b_out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    mux_nway_rr #(.WIDTH(16), .N(8), .SELW(3)) u_dut_a (
        .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
        .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    mux_nway_rr #(.WIDTH(16), .N(5), .SELW(3)) u_dut_b (
        .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
        .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] chan, input logic [15:0] data);
        chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        chk({tag, "_chan"},  32'(a_out_chan),  32'(chan));
        chk({tag, "_data"},  32'(a_out_data),  32'(data));
    endtask

    initial begin
        a_reset = 1'b1; a_in_valid = '0; a_mode = 1'b0; a_sel = '0; a_out_ready = 1'b1;
        b_reset = 1'b1; b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) a_in_data[i*16 +: 16] = 16'hA000 + 16'(i);
        for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = 16'hB000 + 16'(i);

        // Reset state; valids present but ready must stay low.
        a_in_valid = 8'hFF;
        tick(); tick();
        chk("rst_ready",  32'(a_in_ready),  32'h0);
        chk("rst_valid",  32'(a_out_valid), 32'h0);
        chk("rst_data",   32'(a_out_data),  32'h0);
        chk("rst_chan",   32'(a_out_chan),  32'h0);

        // Fixed select of channel 5
        a_reset = 1'b0;
        a_sel = 3'd5; a_in_valid = 8'h20; a_in_data[5*16 +: 16] = 16'hBEEF;
        #1 chk("fix_ready", 32'(a_in_ready), 32'h20);
        tick();
        chk_a("fix", 3'd5, 16'hBEEF);

        // Drain with nothing new: valid drops, data/chan hold
        a_in_valid = 8'h00;
        tick();
        chk("drain_valid", 32'(a_out_valid), 32'h0);
        chk("drain_data",  32'(a_out_data),  32'hBEEF);
        chk("drain_chan",  32'(a_out_chan),  32'h5);
        a_in_data[5*16 +: 16] = 16'hA005;

        // Round-robin streaming from ptr 0: 0..7,0 with no gaps
        a_mode = 1'b1; a_in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            #1 chk("rr_ready", 32'(a_in_ready), 32'(8'(1) << (i % 8)));
            tick();
            chk_a("rr_stream", 3'(i % 8), 16'hA000 + 16'(i % 8));
        end

        // Move ptr to 6 by granting channel 5, then skip/wrap over 8'h05
        a_in_valid = 8'h20;
        tick();
        chk("rr_to6", 32'(a_out_chan), 32'h5);
        a_in_valid = 8'h05;
        tick(); chk_a("rr_wrap0", 3'd0, 16'hA000);
        tick(); chk_a("rr_skip2", 3'd2, 16'hA002);
        tick(); chk_a("rr_wrap0b", 3'd0, 16'hA000);

        // Backpressure for 5 cycles; ptr is now 1
        a_out_ready = 1'b0; a_in_valid = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready", 32'(a_in_ready), 32'h0);
            tick();
            chk_a("bp_hold", 3'd0, 16'hA000);
        end
        a_out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(a_in_ready), 32'h02);
        tick();
        chk_a("bp_next", 3'd1, 16'hA001);

        // Mode change takes effect in the same cycle
        a_mode = 1'b0; a_sel = 3'd3;
        #1 chk("modechg_ready", 32'(a_in_ready), 32'h08);
        tick();
        chk_a("modechg", 3'd3, 16'hA003);

        // Reset mid-operation with a held word; ptr is 2 beforehand
        a_sel = 3'd4; a_in_valid = 8'h10; a_in_data[4*16 +: 16] = 16'h1234;
        tick();
        chk_a("hold1234", 3'd4, 16'h1234);
        a_out_ready = 1'b0; a_in_valid = 8'hFF;
        tick();
        chk_a("hold1234b", 3'd4, 16'h1234);
        a_reset = 1'b1; a_mode = 1'b1;
        #1 chk("midrst_ready", 32'(a_in_ready), 32'h0);
        tick();
        a_reset = 1'b0;
        chk("midrst_valid", 32'(a_out_valid), 32'h0);
        chk("midrst_data",  32'(a_out_data),  32'h0);
        chk("midrst_chan",  32'(a_out_chan),  32'h0);
        a_in_valid = 8'h0A; a_out_ready = 1'b1;
        #1 chk("postrst_ready", 32'(a_in_ready), 32'h02);
        tick();
        chk_a("postrst", 3'd1, 16'hA001);

        // N=5: out-of-range fixed select has no candidate
        b_reset = 1'b0; b_in_valid = 5'h1F; b_sel = 3'd6;
        #1 chk("n5_sel6_ready", 32'(b_in_ready), 32'h0);
        tick();
        chk("n5_sel6_valid", 32'(b_out_valid), 32'h0);
        b_sel = 3'd7;
        #1 chk("n5_sel7_ready", 32'(b_in_ready), 32'h0);
        tick();
        chk("n5_sel7_valid", 32'(b_out_valid), 32'h0);

        // N=5 round-robin: grant 4 wraps ptr to 0
        b_mode = 1'b1; b_in_valid = 5'h10;
        #1 chk("n5_rr4_ready", 32'(b_in_ready), 32'h10);
        tick();
        chk("n5_rr4_chan", 32'(b_out_chan), 32'h4);
        chk("n5_rr4_data", 32'(b_out_data), 32'hB004);
        b_in_valid = 5'h1F;
        #1 chk("n5_wrap_ready", 32'(b_in_ready), 32'h01);
        tick();
        chk("n5_wrap_chan", 32'(b_out_chan), 32'h0);
        #1 chk("n5_next_ready", 32'(b_in_ready), 32'h02);
        tick();
        chk("n5_next_chan", 32'(b_out_chan), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
